// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Two-port writeback arbiter in front of a single register-file write port.
//   Port 0 is the pipeline writeback path and port 1 is the load/multicycle unit.
//   At most one port is accepted per cycle. The accepted write reaches the
//   register file one cycle later, through registered outputs.
//
//   Conflict policy (two requests in a non-stalled cycle):
//     default build             : port 0 wins. Port 1 is forced to win once it
//                                 has lost STARVE_MAX consecutive times.
//     WB_ARB_ROUND_ROBIN_EN set : the port that lost the most recent conflict
//                                 wins. Port 0 is favoured first after reset.
//
// Ports
//   clk_i, rst_i                 clock; asynchronous active-low reset
//   pN_valid_i/addr_i/data_i     request from port N (N = 0, 1)
//   pN_ready_o                   port N accepted this cycle (combinational)
//   stall_i                      register-file write port unavailable this cycle
//   RegWrite_o/RDaddr_o/RDdata_o registered register-file write
//   grant_o                      one-hot port accepted in the previous cycle
//   conflict_cnt_o               saturating count of non-stalled conflict cycles
module reg_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_valid_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ready_o,
  input  logic              p1_valid_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ready_o,
  input  logic              stall_i,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic [1:0]        grant_o,
  output logic [15:0]       conflict_cnt_o
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              conflict_p0;
  logic              p1_wins_p0;
  logic              xfer0_p0;
  logic              xfer1_p0;
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [1:0]        grant_p1;
  logic [15:0]       conflict_cnt;

  // Stage 0: arbitration and handshake
  assign conflict_p0 = p0_valid_i & p1_valid_i & ~stall_i;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Set when port 1 lost the most recent conflict, so it wins the next one.
  logic rr_favor1;

  assign p1_wins_p0 = conflict_p0 & rr_favor1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_favor1 <= 1'b0;
    end else if (conflict_p0) begin
      rr_favor1 <= ~p1_wins_p0;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  assign p1_wins_p0 = conflict_p0 & (starve_cnt == STARVE_LIM);

  // Port 1 can only lose through a conflict. It wins once the count reaches
  // the limit, so the count never goes past STARVE_LIM. A stall cycle is
  // neither a win nor a loss, so it leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= 4'd0;
    end else if (xfer1_p0) begin
      starve_cnt <= 4'd0;
    end else if (p1_valid_i && !stall_i) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  assign xfer0_p0 = p0_valid_i & ~stall_i & ~p1_wins_p0;
  assign xfer1_p0 = p1_valid_i & ~stall_i & (~p0_valid_i | p1_wins_p0);

  assign p0_ready_o = xfer0_p0;
  assign p1_ready_o = xfer1_p0;

  assign vld_p0  = xfer0_p0 | xfer1_p0;
  assign addr_p0 = xfer1_p0 ? p1_addr_i : p0_addr_i;
  assign data_p0 = xfer1_p0 ? p1_data_i : p0_data_i;

  // Stage 1: registered register-file write
  // The asynchronous reset also clears a write that is already in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1       <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
      grant_p1     <= 2'b00;
      conflict_cnt <= 16'd0;
    end else begin
      // A write to address 0 completes the handshake but does not write.
      vld_p1   <= vld_p0 & (addr_p0 != '0);
      grant_p1 <= {xfer1_p0, xfer0_p0};
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
      if (conflict_p0) begin
        conflict_cnt <= sat_inc16(conflict_cnt);
      end
    end
  end

  assign RegWrite_o     = vld_p1;
  assign RDaddr_o       = addr_p1;
  assign RDdata_o       = data_p1;
  assign grant_o        = grant_p1;
  assign conflict_cnt_o = conflict_cnt;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter
//   Directed testbench for reg_wb_arbiter. Expected values are computed by hand.
//   The bench follows the conflict policy selected by WB_ARB_ROUND_ROBIN_EN.
module tb_reg_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              p0_valid_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_data_i;
  logic              p0_ready_o;
  logic              p1_valid_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_data_i;
  logic              p1_ready_o;
  logic              stall_i;
  logic              RegWrite_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic [1:0]        grant_o;
  logic [15:0]       conflict_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_valid_i(p0_valid_i), .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i),
    .p0_ready_o(p0_ready_o),
    .p1_valid_i(p1_valid_i), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_ready_o(p1_ready_o),
    .stall_i(stall_i),
    .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
    .grant_o(grant_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Returns 1 when port 1 should win conflict number idx (0-based).
  function automatic logic p1_expected_win(input int idx);
`ifdef WB_ARB_ROUND_ROBIN_EN
    return (idx % 2) == 1;
`else
    return (idx % 5) == 4;
`endif
  endfunction

  initial begin
    logic p1w;
    int   idx;

    rst_i = 1'b0; stall_i = 1'b0;
    p0_valid_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
    p1_valid_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;

    // Reset state
    tick(); tick();
    check("rst_regwrite", RegWrite_o, 0);
    check("rst_addr", RDaddr_o, 0);
    check("rst_data", RDdata_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_conflict", conflict_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Single port-0 write
    p0_valid_i = 1'b1; p0_addr_i = 5'd5; p0_data_i = 32'h1234;
    #1;
    check("p0_only_ready0", p0_ready_o, 1);
    check("p0_only_ready1", p1_ready_o, 0);
    tick();
    check("p0_only_regwrite", RegWrite_o, 1);
    check("p0_only_addr", RDaddr_o, 5);
    check("p0_only_data", RDdata_o, 32'h1234);
    check("p0_only_grant", grant_o, 2'b01);

    // Idle cycle: the write port holds address and data
    p0_valid_i = 1'b0;
    tick();
    check("idle_regwrite", RegWrite_o, 0);
    check("idle_grant", grant_o, 0);
    check("idle_addr_hold", RDaddr_o, 5);
    check("idle_data_hold", RDdata_o, 32'h1234);

    // Port-1 transfer to address 0
    p1_valid_i = 1'b1; p1_addr_i = 5'd0; p1_data_i = 32'hDEAD;
    #1;
    check("a0_ready1", p1_ready_o, 1);
    check("a0_ready0", p0_ready_o, 0);
    tick();
    check("a0_regwrite", RegWrite_o, 0);
    check("a0_grant", grant_o, 2'b10);

    // Both ports valid for 7 cycles
    p0_valid_i = 1'b1; p0_addr_i = 5'd3; p0_data_i = 32'hA0;
    p1_valid_i = 1'b1; p1_addr_i = 5'd7; p1_data_i = 32'hB0;
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      p1w = p1_expected_win(idx);
      #1;
      check("conf_ready0", p0_ready_o, !p1w);
      check("conf_ready1", p1_ready_o, p1w);
      tick();
      check("conf_grant", grant_o, p1w ? 2'b10 : 2'b01);
      check("conf_data", RDdata_o, p1w ? 32'hB0 : 32'hA0);
      check("conf_regwrite", RegWrite_o, 1);
      idx++;
      if (idx == 5) check("conflict_cnt_5", conflict_cnt_o, 5);
    end
    check("conflict_cnt_7", conflict_cnt_o, 7);

    // Stall with both ports valid
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready0", p0_ready_o, 0);
      check("stall_ready1", p1_ready_o, 0);
      tick();
      check("stall_regwrite", RegWrite_o, 0);
      check("stall_grant", grant_o, 0);
      check("stall_conflict", conflict_cnt_o, 7);
    end
    stall_i = 1'b0;

    // Arbitration resumes from the state held across the stall
    for (int i = 0; i < 3; i++) begin
      p1w = p1_expected_win(idx);
      #1;
      check("resume_ready1", p1_ready_o, p1w);
      tick();
      check("resume_grant", grant_o, p1w ? 2'b10 : 2'b01);
      idx++;
    end
    check("conflict_cnt_10", conflict_cnt_o, 10);

    // Both ports write the same address: port 0 wins, then port 1 writes last
    p0_addr_i = 5'd9; p0_data_i = 32'h11;
    p1_addr_i = 5'd9; p1_data_i = 32'h22;
    #1;
    check("same_ready0", p0_ready_o, 1);
    check("same_ready1", p1_ready_o, 0);
    tick();
    check("same_first_data", RDdata_o, 32'h11);
    check("same_first_grant", grant_o, 2'b01);
    p0_valid_i = 1'b0;
    #1;
    check("same_pending_ready1", p1_ready_o, 1);
    tick();
    check("same_last_addr", RDaddr_o, 9);
    check("same_last_data", RDdata_o, 32'h22);
    check("same_last_grant", grant_o, 2'b10);
    check("conflict_cnt_11", conflict_cnt_o, 11);
    p1_valid_i = 1'b0;

    // Reset asserted between edges, one cycle after a transfer
    p0_valid_i = 1'b1; p0_addr_i = 5'd4; p0_data_i = 32'h55;
    tick();
    check("pre_rst_regwrite", RegWrite_o, 1);
    p0_valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    check("async_rst_regwrite", RegWrite_o, 0);
    check("async_rst_grant", grant_o, 0);
    check("async_rst_conflict", conflict_cnt_o, 0);
    check("async_rst_addr", RDaddr_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // The first edge after reset is a normal arbitration cycle
    p0_valid_i = 1'b1; p0_addr_i = 5'd6; p0_data_i = 32'h77;
    tick();
    check("post_rst_regwrite", RegWrite_o, 1);
    check("post_rst_addr", RDaddr_o, 6);
    check("post_rst_data", RDdata_o, 32'h77);
    check("post_rst_grant", grant_o, 2'b01);
    p0_valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
